// File: rtl/regfile_decoded_sb.sv
// regfile_decoded_sb: register file with an internal one-hot write decoder
// and a busy-bit scoreboard for the pipeline hazard unit.
// Ports:
//   Clk, RST                 - rising-edge clock, asynchronous active-high reset
//   RdAdr1/2, RdData1/2      - two combinational read ports
//   WrEn, WrAdr, WrData      - single write port
//   ResvEn, ResvAdr, ClrAll  - reserve a register / flush all busy bits
//   Busy1/2                  - busy bits of the read addresses
//   BusyVec, BusyCnt         - registered busy bitmap and its population count
//   WrDec                    - registered one-hot of the last accepted write
// Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle writes to the reads
// and to the busy outputs.
module regfile_decoded_sb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                Clk,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   RdAdr1,
  input  logic [ADDR_W-1:0]   RdAdr2,
  output logic [DATA_W-1:0]   RdData1,
  output logic [DATA_W-1:0]   RdData2,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAdr,
  input  logic [DATA_W-1:0]   WrData,
  input  logic                ResvEn,
  input  logic [ADDR_W-1:0]   ResvAdr,
  input  logic                ClrAll,
  output logic                Busy1,
  output logic                Busy2,
  output logic [(1<<ADDR_W)-1:0] BusyVec,
  output logic [ADDR_W:0]     BusyCnt,
  output logic [(1<<ADDR_W)-1:0] WrDec
);
  localparam int NREG = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0] dec, busy_nxt;
  logic [ADDR_W:0] cnt;
  always_comb begin
    dec = '0;
    busy_nxt = '0;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      dec[i] = WrEn && WrAdr == ADDR_W'(i);
      busy_nxt[i] = ClrAll ? 1'b0 :
                    (ResvEn && ResvAdr == ADDR_W'(i)) ? 1'b1 :
                    (WrEn && WrAdr == ADDR_W'(i)) ? 1'b0 : BusyVec[i];
    end
    // register 0 is hard-wired: never written, never busy
    if (ZERO_REG != 0) begin
      dec[0] = 1'b0;
      busy_nxt[0] = 1'b0;
    end
    for (int i = 0; i < NREG; i++)
      cnt = cnt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      BusyVec <= '0;
      BusyCnt <= '0;
      WrDec <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (dec[i]) regs[i] <= WrData;
      BusyVec <= busy_nxt;
      BusyCnt <= cnt;
      WrDec <= dec;
    end
  end
`ifdef REGFILE_WR_BYPASS_EN
  logic byp1, byp2, keep1, keep2;
  always_comb begin
    byp1 = WrEn && RdAdr1 == WrAdr && !(ZERO_REG != 0 && WrAdr == '0);
    byp2 = WrEn && RdAdr2 == WrAdr && !(ZERO_REG != 0 && WrAdr == '0);
    // a same-cycle reservation or flush takes priority over the write's clear
    keep1 = ClrAll || (ResvEn && ResvAdr == RdAdr1);
    keep2 = ClrAll || (ResvEn && ResvAdr == RdAdr2);
    RdData1 = byp1 ? WrData : regs[RdAdr1];
    RdData2 = byp2 ? WrData : regs[RdAdr2];
    Busy1 = (byp1 && !keep1) ? 1'b0 : BusyVec[RdAdr1];
    Busy2 = (byp2 && !keep2) ? 1'b0 : BusyVec[RdAdr2];
  end
`else
  always_comb begin
    RdData1 = regs[RdAdr1];
    RdData2 = regs[RdAdr2];
    Busy1 = BusyVec[RdAdr1];
    Busy2 = BusyVec[RdAdr2];
  end
`endif
endmodule

// File: tb/tb_regfile_decoded_sb.sv
// tb_regfile_decoded_sb: directed self-checking bench for regfile_decoded_sb.
module tb_regfile_decoded_sb;
  logic        Clk = 0, RST = 0;
  logic [4:0]  RdAdr1 = 0, RdAdr2 = 0, WrAdr = 0, ResvAdr = 0;
  logic [31:0] RdData1, RdData2, WrData = 0;
  logic        WrEn = 0, ResvEn = 0, ClrAll = 0, Busy1, Busy2;
  logic [31:0] BusyVec, WrDec;
  logic [5:0]  BusyCnt;
  int errors = 0, checks = 0;
  regfile_decoded_sb dut (
    .Clk(Clk), .RST(RST), .RdAdr1(RdAdr1), .RdAdr2(RdAdr2),
    .RdData1(RdData1), .RdData2(RdData2), .WrEn(WrEn), .WrAdr(WrAdr),
    .WrData(WrData), .ResvEn(ResvEn), .ResvAdr(ResvAdr), .ClrAll(ClrAll),
    .Busy1(Busy1), .Busy2(Busy2), .BusyVec(BusyVec), .BusyCnt(BusyCnt),
    .WrDec(WrDec)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #3 RST = 1;
    #1;
    chk("rst_rd1", RdData1, 0);
    chk("rst_rd2", RdData2, 0);
    chk("rst_busyvec", BusyVec, 0);
    chk("rst_busycnt", BusyCnt, 0);
    chk("rst_wrdec", WrDec, 0);
    chk("rst_busy1", Busy1, 0);
    #3 RST = 0;
    for (int k = 0; k < 32; k++) begin
      WrEn = 1; WrAdr = 5'(k); WrData = 32'hA500_0000 + k;
      step;
      chk($sformatf("wrdec_%0d", k), WrDec, k == 0 ? 32'd0 : 32'd1 << k);
    end
    WrEn = 0;
    step;
    chk("wrdec_idle", WrDec, 0);
    for (int k = 0; k < 32; k++) begin
      RdAdr1 = 5'(k); RdAdr2 = 5'(31 - k);
      #1;
      chk($sformatf("sweep_rd1_%0d", k), RdData1, k == 0 ? 32'd0 : 32'hA500_0000 + k);
      chk($sformatf("sweep_rd2_%0d", 31 - k), RdData2, k == 31 ? 32'd0 : 32'hA500_0000 + 31 - k);
    end
    WrEn = 1; WrAdr = 7; WrData = 32'h1234_5678;
    step;
    WrData = 32'hDEAD_BEEF; RdAdr1 = 7; RdAdr2 = 7;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("same_cycle_rd1", RdData1, 32'hDEAD_BEEF);
    chk("same_cycle_rd2", RdData2, 32'hDEAD_BEEF);
`else
    chk("same_cycle_rd1", RdData1, 32'h1234_5678);
    chk("same_cycle_rd2", RdData2, 32'h1234_5678);
`endif
    step;
    WrEn = 0;
    #1;
    chk("after_write_rd1", RdData1, 32'hDEAD_BEEF);
    ResvEn = 1; ResvAdr = 3;
    step;
    chk("resv3_cnt", BusyCnt, 1);
    ResvAdr = 8;
    step;
    chk("resv8_cnt", BusyCnt, 2);
    ResvAdr = 31;
    step;
    chk("resv31_cnt", BusyCnt, 3);
    chk("resv_vec", BusyVec, 32'h8000_0108);
    ResvEn = 0; WrEn = 1; WrAdr = 8; WrData = 32'h0000_0888; RdAdr1 = 8; RdAdr2 = 3;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("busy1_same_cycle", Busy1, 0);
`else
    chk("busy1_same_cycle", Busy1, 1);
`endif
    step;
    WrEn = 0;
    #1;
    chk("wr8_cnt", BusyCnt, 2);
    chk("wr8_busy1", Busy1, 0);
    chk("wr8_busy2", Busy2, 1);
    chk("wr8_vec", BusyVec, 32'h8000_0008);
    chk("wr8_data", RdData1, 32'h0000_0888);
    ResvEn = 1; ResvAdr = 5; WrEn = 1; WrAdr = 5; WrData = 32'h55;
    step;
    chk("resv_wr5_vec", BusyVec, 32'h8000_0028);
    chk("resv_wr5_cnt", BusyCnt, 3);
    WrEn = 0; ResvAdr = 3;
    step;
    chk("rerserve3_vec", BusyVec, 32'h8000_0028);
    chk("rerserve3_cnt", BusyCnt, 3);
    ClrAll = 1; ResvAdr = 9;
    step;
    chk("clrall_vec", BusyVec, 0);
    chk("clrall_cnt", BusyCnt, 0);
    ClrAll = 0; ResvAdr = 0; WrEn = 1; WrAdr = 0; WrData = 32'hFFFF_FFFF;
    RdAdr1 = 0; RdAdr2 = 0;
    step;
    ResvEn = 0; WrEn = 0;
    #1;
    chk("zero_vec", BusyVec, 0);
    chk("zero_cnt", BusyCnt, 0);
    chk("zero_wrdec", WrDec, 0);
    chk("zero_rd1", RdData1, 0);
    chk("zero_rd2", RdData2, 0);
    ResvEn = 1; ResvAdr = 4;
    step;
    chk("resv4_cnt", BusyCnt, 1);
    ResvEn = 0; WrEn = 1; WrAdr = 10; WrData = 32'hCAFE_0010; RdAdr1 = 7;
    #2 RST = 1;
    #1;
    chk("midrst_rd7", RdData1, 0);
    chk("midrst_vec", BusyVec, 0);
    chk("midrst_cnt", BusyCnt, 0);
    @(posedge Clk);
    #1 RST = 0; WrEn = 0; RdAdr1 = 10;
    #1;
    chk("midrst_rd10", RdData1, 0);
    chk("midrst_wrdec", WrDec, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_decoded_sb.md
Name: regfile_decoded_sb

Overview:
- Parametrised register file for the MIPS datapath; successor to the fixed 5-to-32 write decoder.
- Write address decoded internally to a one-hot enable vector of width 2^ADDR_W; one write port, two asynchronous read ports.
- Integrated busy-bit scoreboard: registers reserved at issue, released on writeback, for the pipeline hazard unit.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

Parameters:
- ADDR_W, 5, register address width; NREG = 2^ADDR_W registers.
- DATA_W, 32, register data width.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and can never be busy.

Ports:
- Clk  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- RdAdr1  input  ADDR_W  read port 1 address
- RdAdr2  input  ADDR_W  read port 2 address
- RdData1  output  DATA_W  read port 1 data (combinational)
- RdData2  output  DATA_W  read port 2 data (combinational)
- WrEn  input  1  write enable
- WrAdr  input  ADDR_W  write address
- WrData  input  DATA_W  write data
- ResvEn  input  1  reserve (set busy) request
- ResvAdr  input  ADDR_W  register to reserve
- ClrAll  input  1  synchronous flush of all busy bits
- Busy1  output  1  busy bit of RdAdr1 (combinational)
- Busy2  output  1  busy bit of RdAdr2 (combinational)
- BusyVec  output  NREG  registered busy bitmap
- BusyCnt  output  ADDR_W+1  registered count of set busy bits
- WrDec  output  NREG  registered one-hot of the last accepted write, 0 if none that cycle

Behaviour:
- Reset: RST asserted asynchronously forces the following, regardless of Clk:
  - all registers, BusyVec, BusyCnt and WrDec to 0;
  - RdData1/2 therefore read 0 and Busy1/2 read 0.
- Reset mid-operation discards pending writes and reservations. First update occurs on the first rising edge after RST deasserts.
- Write decode:
  - dec = one-hot of WrAdr, gated by WrEn.
  - When ZERO_REG=1, bit 0 of dec is forced to 0.
  - On the rising edge, every register whose dec bit is 1 loads WrData (at most one).
  - WrDec <= dec each cycle; this is 1-cycle latency, and WrDec = 0 in cycles with no accepted write.
- Reads:
  - RdDataN = reg[RdAdrN], purely combinational.
  - Reading register 0 with ZERO_REG=1 returns 0.
  - A read of an address written in the same cycle returns the old value, except as changed by the optional feature below.
  - Both ports may read the same address.
- Scoreboard, per bit i, evaluated at each rising edge in priority order:
  - ClrAll=1 -> 0;
  - else ResvEn && ResvAdr==i -> 1;
  - else WrEn && WrAdr==i -> 0;
  - else hold.
- Scoreboard boundary cases:
  - Reserve and write to the same address in the same cycle: the reservation wins and the bit ends 1 (a newer producer is in flight).
  - Reserving an already-busy register: it stays 1, with no error.
  - Writing a non-busy register: a normal write; the bit stays 0.
  - With ZERO_REG=1, bit 0 is never set.
- Busy1/Busy2 = BusyVec[RdAdr1/2], combinational from the registered bitmap; same-cycle reservations are not visible until the next cycle.
- BusyCnt is the population count of the next-state bitmap, registered together with BusyVec and always consistent with it. Range is 0..NREG, so NREG fits in ADDR_W+1 bits.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - if WrEn=1 and RdAdrN==WrAdr (excluding address 0 when ZERO_REG=1), RdDataN = WrData in that same cycle;
  - likewise BusyN reads 0 when that write clears the bit and no same-cycle reservation or ClrAll targets it.
- Not defined: reads and busy outputs return registered state only, i.e. the old value during a same-cycle write.

Test Plan (ADDR_W=5, DATA_W=32, ZERO_REG=1):
- Reset check: pulse RST between clock edges -> RdData1/2=0 immediately; BusyVec=0; BusyCnt=0; WrDec=0.
- Write-then-read sweep: write addr k with data 0xA5000000+k for k=0..31, then read every k on both ports -> reg0 reads 0; others read 0xA5000000+k; WrDec=1<<k one cycle after each write (0 for k=0).
- Same-cycle write/read of addr 7 with 0xDEADBEEF, previous value 0x12345678 -> without the macro RdData1=0x12345678 that cycle; with REGFILE_WR_BYPASS_EN RdData1=0xDEADBEEF.
- Reserve regs 3, 8 and 31 on successive cycles, then write reg 8 -> BusyCnt goes 1,2,3 then 2; Busy1 with RdAdr1=8 reads 0 after the write.
- ResvEn and WrEn both on addr 5 in the same cycle -> BusyVec[5]=1; then ClrAll together with ResvEn on addr 9 -> BusyVec=0 and BusyCnt=0.
- Reserve addr 0 and write addr 0 with 0xFFFFFFFF -> BusyVec[0]=0; RdData reads 0 at addr 0; WrDec=0.
